// File: rtl/ram_seq_ctrl.sv
// rtl/ram_seq_ctrl.sv - load/playback sequencer for the 64x8 single-port sample buffer
// Fills the buffer from the byte stream, then replays a (optionally sliding) window.
module ram_seq_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 8,
  parameter int WIN   = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Ld,
  input  logic          Start,
  input  logic          Sliding,
  input  logic [DW-1:0] Data_in,
  output logic          Ram_we,
  output logic [AW-1:0] Ram_addr,
  output logic [DW-1:0] Ram_wdata,
  input  logic [DW-1:0] Ram_rdata,
  output logic [DW-1:0] Dout,
  output logic          Dout_vld,
  output logic [AW:0]   Cursor,
  output logic          Empty,
  output logic          Full,
  output logic          using
);

  typedef enum logic [1:0] {IDLE, LOAD, READY, PLAY} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] OFF_LAST = (AW+1)'(WIN - 1);
  localparam logic [AW:0] CUR_LAST = (AW+1)'(DEPTH - WIN);

  state_t          state, state_next;
  logic [AW:0]     wr_ptr, count, count_next, rd_off;
  logic [AW-1:0]   rd_addr;
  logic            do_write, do_read, do_wrap, do_slide, do_end;
  logic            addr_vld, rdata_vld;

  assign rd_addr = AW'(Cursor + rd_off);

  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_read    = 1'b0;
    do_wrap    = 1'b0;
    do_slide   = 1'b0;
    do_end     = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (Ld) begin
          do_write   = 1'b1;
          state_next = (count == CNT_LAST) ? READY : LOAD;
        end
      end
      READY: begin
        if (Start) state_next = PLAY;
      end
      PLAY: begin
        if (!Start) begin
          state_next = READY;
        end else begin
          do_read = 1'b1;
          if (rd_off == OFF_LAST) begin
            do_wrap = 1'b1;
            // Sliding only matters here, so a mid-pass change waits for the wrap
            if (Sliding) begin
              if (Cursor == CUR_LAST) begin
                do_end     = 1'b1;
                state_next = IDLE;
              end else begin
                do_slide = 1'b1;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (do_end)
      count_next = '0;
    else if (do_write)
      count_next = count + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      rd_off    <= '0;
      Cursor    <= '0;
      Ram_we    <= 1'b0;
      Ram_addr  <= '0;
      Ram_wdata <= '0;
      addr_vld  <= 1'b0;
      rdata_vld <= 1'b0;
      Dout      <= '0;
      Dout_vld  <= 1'b0;
      Empty     <= 1'b1;
      Full      <= 1'b0;
      using     <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      Empty <= (count_next == '0);
      Full  <= (count_next == CNT_FULL);
      using <= (state_next == PLAY);

      // Writes and reads live in disjoint states, so the address port is never shared
      Ram_we <= do_write;
      if (do_write) begin
        Ram_addr  <= wr_ptr[AW-1:0];
        Ram_wdata <= Data_in;
      end else if (do_read) begin
        Ram_addr <= rd_addr;
      end

      if (do_end)
        wr_ptr <= '0;
      else if (do_write)
        wr_ptr <= wr_ptr + 1'b1;

      if (do_read && !do_wrap)
        rd_off <= rd_off + 1'b1;
      else
        rd_off <= '0;

      if (do_end)
        Cursor <= '0;
      else if (do_slide)
        Cursor <= Cursor + 1'b1;

      // Address -> RAM data -> Dout; in-flight reads drain even after a pause
      addr_vld  <= do_read;
      rdata_vld <= addr_vld;
      Dout_vld  <= rdata_vld;
      if (rdata_vld)
        Dout <= Ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb/tb_ram_seq_ctrl.sv - randomized self-checking bench for ram_seq_ctrl
// Buffer contents and playback streams are predicted from the load/window rules.
module tb_ram_seq_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int WIN   = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Ld = 1'b0;
  logic          Start = 1'b0;
  logic          Sliding = 1'b0;
  logic [DW-1:0] Data_in = '0;
  logic          Ram_we;
  logic [AW-1:0] Ram_addr;
  logic [DW-1:0] Ram_wdata;
  logic [DW-1:0] Ram_rdata = '0;
  logic [DW-1:0] Dout;
  logic          Dout_vld;
  logic [AW:0]   Cursor;
  logic          Empty;
  logic          Full;
  logic          using;

  ram_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .WIN(WIN)) dut (
    .Clk(Clk), .Rst(Rst), .Ld(Ld), .Start(Start), .Sliding(Sliding),
    .Data_in(Data_in), .Ram_we(Ram_we), .Ram_addr(Ram_addr),
    .Ram_wdata(Ram_wdata), .Ram_rdata(Ram_rdata), .Dout(Dout),
    .Dout_vld(Dout_vld), .Cursor(Cursor), .Empty(Empty), .Full(Full),
    .using(using)
  );

  always #10 Clk = ~Clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge Clk) begin
    if (Ram_we) mem[Ram_addr] <= Ram_wdata;
    Ram_rdata <= mem[Ram_addr];
  end

  int            n_chk = 0;
  int            n_err = 0;
  int            bad_we = 0;
  logic [DW-1:0] bufm [DEPTH];
  logic [DW-1:0] outq [$];
  logic [DW-1:0] expq [$];

  always @(negedge Clk) if (Rst && Dout_vld) outq.push_back(Dout);

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic compare_stream(input string tag);
    check_eq({tag, "_len"}, outq.size(), expq.size());
    for (int k = 0; k < outq.size() && k < expq.size(); k++)
      check_eq(tag, int'(outq[k]), int'(expq[k]));
  endtask

  task automatic load_buffer(input bit rand_mode);
    int cnt;
    bit acc;
    cnt = 0;
    for (int e = 0; e < 400 && cnt < DEPTH; e++) begin
      Ld      = (!rand_mode || e == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      Start   = rand_mode ? ((e == 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      Data_in = rand_mode ? DW'($urandom) : DW'(cnt);
      @(negedge Clk);
      acc = Ld;
      if (acc) begin
        bufm[cnt] = Data_in;
        cnt++;
      end
      check_eq("load_we", int'(Ram_we), int'(acc));
      if (acc) begin
        check_eq("load_addr", int'(Ram_addr), cnt - 1);
        check_eq("load_data", int'(Ram_wdata), int'(bufm[cnt-1]));
      end
      check_eq("load_full", int'(Full), int'(cnt == DEPTH));
      check_eq("load_empty", int'(Empty), int'(cnt == 0));
      check_eq("load_using", int'(using), 0);
    end
    check_eq("load_count", cnt, DEPTH);
    Start   = 1'b0;
    Ld      = 1'b1;
    Data_in = 8'hA5;
    @(negedge Clk);
    check_eq("extra_ld_we", int'(Ram_we), 0);
    check_eq("extra_ld_full", int'(Full), 1);
    check_eq("ready_using", int'(using), 0);
    Ld = 1'b0;
  endtask

  // Holds Start high; Sliding is random mid-pass and forced to 'slide' on wrap edges.
  task automatic run_play(input int max_e, input bit slide, input bit until_idle,
                          output int n_edges, output int t_use, output int t_vld);
    n_edges = -1;
    t_use   = -1;
    t_vld   = -1;
    for (int e = 1; e <= max_e; e++) begin
      Start   = 1'b1;
      Ld      = 1'($urandom_range(0, 1));
      Sliding = (e >= 2 && (e - 1) % WIN == 0) ? slide : 1'($urandom_range(0, 1));
      @(negedge Clk);
      if (Ram_we !== 1'b0) bad_we++;
      if (using && t_use < 0) t_use = e;
      if (Dout_vld && t_vld < 0) t_vld = e;
      n_edges = e;
      if (until_idle && e > 1 && !using) break;
    end
    Ld      = 1'b0;
    Sliding = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n, tu, tv;

    // Reset
    repeat (5) @(negedge Clk);
    check_eq("rst_empty", int'(Empty), 1);
    check_eq("rst_full", int'(Full), 0);
    check_eq("rst_using", int'(using), 0);
    check_eq("rst_cursor", int'(Cursor), 0);
    check_eq("rst_dout_vld", int'(Dout_vld), 0);
    check_eq("rst_we", int'(Ram_we), 0);
    check_eq("rst_addr", int'(Ram_addr), 0);
    check_eq("rst_dout", int'(Dout), 0);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);

    // Sequential load, then play without sliding
    load_buffer(1'b0);
    outq.delete();
    run_play(21, 1'b0, 1'b0, n, tu, tv);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    check_eq("play_using_edge", tu, 1);
    check_eq("play_latency", tv - tu, 3);
    expq.delete();
    for (int k = 0; k < 20; k++) expq.push_back(bufm[k % WIN]);
    compare_stream("noslide");
    check_eq("noslide_cursor", int'(Cursor), 0);
    check_eq("pause_using", int'(using), 0);
    check_eq("pause_full", int'(Full), 1);
    check_eq("pause_dout_vld", int'(Dout_vld), 0);

    // Slide three windows, pause at Cursor=3
    outq.delete();
    run_play(25, 1'b1, 1'b0, n, tu, tv);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    expq.delete();
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < WIN; i++) expq.push_back(bufm[w + i]);
    compare_stream("slide_a");
    check_eq("pause3_cursor", int'(Cursor), 3);
    check_eq("pause3_using", int'(using), 0);
    check_eq("pause3_full", int'(Full), 1);
    check_eq("pause3_empty", int'(Empty), 0);

    // Resume and slide to the end of the buffer
    outq.delete();
    run_play(600, 1'b1, 1'b1, n, tu, tv);
    Start = 1'b0;
    check_eq("end_edges", n, (DEPTH - WIN - 3 + 1) * WIN + 1);
    repeat (4) @(negedge Clk);
    expq.delete();
    for (int w = 3; w <= DEPTH - WIN; w++)
      for (int i = 0; i < WIN; i++) expq.push_back(bufm[w + i]);
    compare_stream("slide_b");
    check_eq("end_empty", int'(Empty), 1);
    check_eq("end_full", int'(Full), 0);
    check_eq("end_using", int'(using), 0);
    check_eq("end_cursor", int'(Cursor), 0);

    // Random load with gaps, play, then asynchronous reset mid-play
    load_buffer(1'b1);
    outq.delete();
    run_play(12, 1'b0, 1'b0, n, tu, tv);
    #2 Rst = 1'b0;
    #1;
    check_eq("arst_empty", int'(Empty), 1);
    check_eq("arst_full", int'(Full), 0);
    check_eq("arst_using", int'(using), 0);
    check_eq("arst_cursor", int'(Cursor), 0);
    check_eq("arst_dout_vld", int'(Dout_vld), 0);
    check_eq("arst_dout", int'(Dout), 0);
    check_eq("arst_we", int'(Ram_we), 0);
    check_eq("arst_addr", int'(Ram_addr), 0);
    expq.delete();
    for (int k = 0; k < 9; k++) expq.push_back(bufm[k % WIN]);
    compare_stream("rand_play");
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check_eq("idle_start_using", int'(using), 0);
    check_eq("idle_start_empty", int'(Empty), 1);
    check_eq("idle_start_vld", int'(Dout_vld), 0);
    Start = 1'b0;
    check_eq("no_we_in_play", bad_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
# ram_seq_ctrl

Sequencing controller for the 64×8 single-port sample buffer. It fills the buffer from the byte stream while `Ld` is high, then on `Start` plays it back as a repeating window of `WIN` bytes beginning at `Cursor`. `Sliding` advances that window one byte per pass. It sits between the input byte stream and the synchronous RAM macro, owns every RAM address/enable, and drives the buffer status flags and the playback byte stream.

## Interface
- `DEPTH`, 64, buffer entries (power of two)
- `AW`, 6, RAM address width, log2(DEPTH)
- `DW`, 8, data width
- `WIN`, 8, playback window length, 1..DEPTH
- `Clk` in 1, system clock (50 MHz)
- `Rst` in 1, reset, asynchronous, active-low (0 = reset)
- `Ld` in 1, load enable; one byte accepted per cycle while high
- `Start` in 1, level; high = play, low = pause
- `Sliding` in 1, level; high = advance window after each pass
- `Data_in` in DW, byte to store, sampled with `Ld`
- `Ram_we` out 1, RAM write enable
- `Ram_addr` out AW, RAM address
- `Ram_wdata` out DW, RAM write data
- `Ram_rdata` in DW, RAM read data, valid one cycle after address
- `Dout` out DW, playback byte
- `Dout_vld` out 1, `Dout` valid strobe
- `Cursor` out AW+1, window base, 0..DEPTH-WIN
- `Empty` out 1, byte count == 0
- `Full` out 1, byte count == DEPTH
- `using` out 1, controller in PLAY

## Operation
- State machine states: IDLE, LOAD, READY, PLAY. Counters: `wr_ptr`/`count` (AW+1 bits), `rd_off` (0..WIN-1), `Cursor`.
- IDLE: `Empty`=1. `Ld`=1 → LOAD, and that cycle's byte is accepted. `Start` is ignored.
- LOAD: each cycle with `Ld`=1 writes `Data_in` to `wr_ptr`, then increments `wr_ptr` and `count`. `Ld`=0 pauses the load with no write.
  - When the 64th byte is accepted, the FSM goes to READY. Further `Ld` is ignored and no overwrite occurs.
  - `Start` in LOAD is ignored until the buffer is full.
- READY: `Full`=1. `Start`=1 → PLAY, `rd_off`=0.
- PLAY: `using`=1. Each cycle issues a read at `(Cursor + rd_off)`. `rd_off` wraps from WIN-1 to 0.
  - At the wrap, if `Sliding`=1, `Cursor` is incremented. If `Sliding`=0, the same window repeats.
  - A slide requested when `Cursor` = DEPTH-WIN ends playback. The FSM goes to IDLE, `count`, `wr_ptr` and `Cursor` clear, and the buffer is released (`Empty`=1).
- `Start`=0 in PLAY → READY. Reads already issued still complete on `Dout`. `Cursor` is held and `rd_off` resets to 0 on resume.
- `Ld` is ignored in READY and PLAY.
- Simultaneous events:
  - `Ld` and `Start` together in IDLE: load wins.
  - `Sliding` change mid-pass takes effect only at the next wrap.
- `Ram_we` is never asserted in the same cycle as a read address.

## Timing
- All outputs are registered.
- Reset values: `Ram_we`=0, `Ram_addr`=0, `Ram_wdata`=0, `Dout`=0, `Dout_vld`=0, `Cursor`=0, `Empty`=1, `Full`=0, `using`=0, state=IDLE.
- Write path: `Ld`/`Data_in` sampled at edge n; `Ram_we`/`Ram_addr`/`Ram_wdata` are valid after edge n, and the RAM writes at edge n+1.
- Flags: `Empty` falls and `Full` rises the cycle after the accepting edge. `Full` rises after the edge that accepts byte 64.
- Read path: address is issued after edge n; `Ram_rdata` is valid after edge n+1; `Dout`/`Dout_vld` are registered after edge n+2. Latency from READY→PLAY transition to first `Dout_vld` is 3 cycles.
- In steady PLAY, `Dout_vld` is continuous at 1 byte/cycle.
- `Cursor` updates on the edge that wraps `rd_off`.
- `Rst` low at any time forces reset values immediately (asynchronously). Buffer contents are considered lost and a new load is required.

## Test plan
- Reset: hold `Rst`=0 for 5 cycles → `Empty`=1, `Full`=0, `using`=0, `Cursor`=0, `Dout_vld`=0, no `Ram_we`.
- Load: `Ld`=1 for 64 cycles with `Data_in`=0..63 → 64 writes to addr 0..63 with data = addr. `Full`=1 after the 64th byte. A 65th `Ld` cycle produces no `Ram_we`.
- Load pause: `Ld` toggles 1/0 for 128 cycles → exactly 64 writes, addresses contiguous, `Full` set only after the 64th write.
- Play, no slide: `Start`=1, `Sliding`=0 → `Dout` = 0,1,…,7,0,1,… with first `Dout_vld` 3 cycles after `Start`; `Cursor` stays 0.
- Slide to end: `Sliding`=1 → successive windows start at 0,1,2,…; `Cursor` steps once per 8 bytes. After the window at `Cursor`=56 the FSM returns to IDLE with `Empty`=1, `using`=0.
- Pause and reset mid-play: `Start`=0 at `Cursor`=3 → `using`=0, `Cursor` holds 3, `Full`=1. On resume, `Dout` starts at 3. Pulse `Rst` low during PLAY → all outputs return to reset values immediately.
